// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command frame parser.
package uart_cmd_parser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CODE_W = 2;

  localparam logic [BYTE_W-1:0] HEADER = 8'hAA;

  localparam int unsigned TIMEOUT_CYCLES = 50000;

  localparam logic [DATA_W-1:0] ON_TIME_MAX     = 16'd400;
  localparam logic [DATA_W-1:0] ON_TIME_DEFAULT = 16'd0;
  localparam logic [DATA_W-1:0] PERIOD_DEFAULT  = 16'd10000;

  localparam logic [BYTE_W-1:0] CMD_ON_TIME = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_PERIOD  = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_ENABLE  = 8'h03;

  localparam logic [CODE_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [CODE_W-1:0] ERR_CHK     = 2'd1;
  localparam logic [CODE_W-1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [CODE_W-1:0] ERR_CMD     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_CHECK   = 3'd4
  } state_e;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_byte_timeout.sv
// Inter-byte watchdog: flags when a frame stalls for CYCLES clocks.
module uart_cmd_parser_byte_timeout
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned CYCLES = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CW = cnt_width(CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A byte always beats a coincident expiry, so clear masks the strobe.
  assign expire_c = run && !clear && (cnt_q == LIMIT);

  // Next count: reset on byte, idle or expiry, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run || expire_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames from the UART byte stream and applies
// validated commands to the interrupter settings registers.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = uart_cmd_parser_pkg::TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] on_time,
  output logic [15:0] period,
  output logic        out_en,
  output logic        cmd_ok,
  output logic        err,
  output logic [1:0]  err_code
);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   on_time_q, on_time_d;
  logic [DATA_W-1:0]   period_q, period_d;
  logic                out_en_q, out_en_d;
  logic                cmd_ok_q, cmd_ok_d;
  logic                err_q, err_d;
  logic [CODE_W-1:0]   err_code_q, err_code_d;

  logic                expire_c;
  logic [BYTE_W-1:0]   chk_c;
  logic [DATA_W-1:0]   data_c;

  assign chk_c  = cmd_q ^ lo_q ^ hi_q;
  assign data_c = {hi_q, lo_q};

  uart_cmd_parser_byte_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (byte_valid),
    .run      (state_q != ST_IDLE),
    .expire_c (expire_c)
  );

  // Frame sequencing, validation and register update.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    on_time_d  = on_time_q;
    period_d   = period_q;
    out_en_d   = out_en_q;
    err_code_d = err_code_q;
    cmd_ok_d   = 1'b0;
    err_d      = 1'b0;

    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_in == HEADER) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_d   = byte_in;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          lo_d    = byte_in;
          state_d = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          hi_d    = byte_in;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (byte_in != chk_c) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end else begin
            case (cmd_q)
              CMD_ON_TIME: begin
                on_time_d = (data_c > ON_TIME_MAX) ? ON_TIME_MAX : data_c;
                cmd_ok_d  = 1'b1;
              end
              CMD_PERIOD: begin
                if (data_c == '0) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CMD;
                end else begin
                  period_d = data_c;
                  cmd_ok_d = 1'b1;
                end
              end
              CMD_ENABLE: begin
                out_en_d = lo_q[0];
                cmd_ok_d = 1'b1;
              end
              default: begin
                err_d      = 1'b1;
                err_code_d = ERR_CMD;
              end
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire_c) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  // State and settings registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      on_time_q  <= ON_TIME_DEFAULT;
      period_q   <= PERIOD_DEFAULT;
      out_en_q   <= 1'b0;
      cmd_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      on_time_q  <= on_time_d;
      period_q   <= period_d;
      out_en_q   <= out_en_d;
      cmd_ok_q   <= cmd_ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign on_time  = on_time_q;
  assign period   = period_q;
  assign out_en   = out_en_q;
  assign cmd_ok   = cmd_ok_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with a shortened timeout.
module tb_uart_cmd_parser;

  localparam int unsigned T = 100;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [15:0] on_t;
    logic [15:0] per;
    logic        en;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [15:0] on_time;
  logic [15:0] period;
  logic        out_en;
  logic        cmd_ok;
  logic        err;
  logic [1:0]  err_code;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .on_time    (on_time),
    .period     (period),
    .out_en     (out_en),
    .cmd_ok     (cmd_ok),
    .err        (err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_defaults(input string tag);
    check({tag, " on_time"},  on_time,         16'd0);
    check({tag, " period"},   period,          16'd10000);
    check({tag, " out_en"},   16'(out_en),     16'd0);
    check({tag, " cmd_ok"},   16'(cmd_ok),     16'd0);
    check({tag, " err"},      16'(err),        16'd0);
    check({tag, " err_code"}, 16'(err_code),   16'd0);
  endtask

  task automatic expect_evt(input logic is_err, input logic [1:0] code,
                            input logic [15:0] on_t, input logic [15:0] per,
                            input logic en);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.on_t   = on_t;
    e.per    = per;
    e.en     = en;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send(b0); send(b1); send(b2); send(b3); send(b4);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cmd_ok/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (cmd_ok || err)) begin
      exp_t e;
      check("ok_err_exclusive", 16'(cmd_ok && err), 16'd0);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_event: got cmd_ok=%0b err=%0b, expected none", cmd_ok, err);
      end else begin
        e = exp_q.pop_front();
        check("evt_err",      16'(err),      16'(e.is_err));
        check("evt_cmd_ok",   16'(cmd_ok),   16'(!e.is_err));
        check("evt_err_code", 16'(err_code), 16'(e.code));
        check("evt_on_time",  on_time,       e.on_t);
        check("evt_period",   period,        e.per);
        check("evt_out_en",   16'(out_en),   16'(e.en));
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    byte_valid   = 1'b0;
    byte_in      = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_defaults("reset");

    // on_time = 0x012C = 300
    expect_evt(1'b0, 2'd0, 16'd300, 16'd10000, 1'b0);
    send5(8'hAA, 8'h01, 8'h2C, 8'h01, 8'h2C);
    idle(2);

    // 0x01F4 = 500 clamps to 400
    expect_evt(1'b0, 2'd0, 16'd400, 16'd10000, 1'b0);
    send5(8'hAA, 8'h01, 8'hF4, 8'h01, 8'hF4);
    idle(2);

    // corrupted checksum (0x35 -> 0x36)
    expect_evt(1'b1, 2'd1, 16'd400, 16'd10000, 1'b0);
    send5(8'hAA, 8'h02, 8'h10, 8'h27, 8'h36);
    idle(2);

    // enable; err_code held at 1
    expect_evt(1'b0, 2'd1, 16'd400, 16'd10000, 1'b1);
    send5(8'hAA, 8'h03, 8'h01, 8'h00, 8'h02);
    idle(2);

    // stall after AA 01 for T cycles -> timeout
    expect_evt(1'b1, 2'd2, 16'd400, 16'd10000, 1'b1);
    send(8'hAA);
    send(8'h01);
    idle(T);
    // period = 0x1388 = 5000, chk 02^88^13 = 99
    expect_evt(1'b0, 2'd2, 16'd400, 16'd5000, 1'b1);
    send5(8'hAA, 8'h02, 8'h88, 8'h13, 8'h99);
    idle(2);

    // garbage then unknown command
    expect_evt(1'b1, 2'd3, 16'd400, 16'd5000, 1'b1);
    send(8'h55);
    send(8'h00);
    send5(8'hAA, 8'h07, 8'h00, 8'h00, 8'h07);
    idle(2);

    // zero period rejected
    expect_evt(1'b1, 2'd3, 16'd400, 16'd5000, 1'b1);
    send5(8'hAA, 8'h02, 8'h00, 8'h00, 8'h02);
    idle(2);

    // HEADER byte as data: on_time = 0x00AA = 170
    expect_evt(1'b0, 2'd3, 16'd170, 16'd5000, 1'b1);
    send5(8'hAA, 8'h01, 8'hAA, 8'h00, 8'hAB);
    idle(2);

    // back-to-back frames, no dead cycle
    expect_evt(1'b0, 2'd3, 16'd100, 16'd5000, 1'b1);
    expect_evt(1'b0, 2'd3, 16'd100, 16'd5000, 1'b0);
    send5(8'hAA, 8'h01, 8'h64, 8'h00, 8'h65);
    send5(8'hAA, 8'h03, 8'h00, 8'h00, 8'h03);
    idle(2);

    // DATA_LO byte lands exactly on the expiry cycle: byte wins
    expect_evt(1'b0, 2'd3, 16'd100, 16'd5000, 1'b1);
    send(8'hAA);
    send(8'h03);
    idle(T - 1);
    send(8'h01);
    send(8'h00);
    send(8'h02);
    idle(2);

    // reset mid-frame
    send(8'hAA);
    send(8'h01);
    rst_n = 1'b0;
    #1;
    check_defaults("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check_defaults("postreset");
    // tail of the aborted frame must be ignored in IDLE
    send(8'h2C);
    send(8'h01);
    send(8'h2C);
    idle(T + 5);
    expect_evt(1'b0, 2'd0, 16'd0, 16'd10000, 1'b1);
    send5(8'hAA, 8'h03, 8'h01, 8'h00, 8'h02);
    idle(10);

    check("pending_events", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the byte stream from the UART receiver (8-bit byte plus one-cycle ready strobe) and assembles fixed 5-byte command frames.
- Validates each frame and updates the interrupter settings registers: pulse on-time, burst period and output enable.
- Sits between the UART receiver and the pulse generator. Frame format: HEADER, CMD, DATA_LO, DATA_HI, CHK, where CHK = CMD ^ DATA_LO ^ DATA_HI.

Parameters:
HEADER, 8'hAA, frame start byte
TIMEOUT_CYCLES, 50000, max clk cycles allowed between consecutive bytes of one frame
ON_TIME_MAX, 16'd400, upper clamp for on_time
ON_TIME_DEFAULT, 16'd0, reset value of on_time
PERIOD_DEFAULT, 16'd10000, reset value of period

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
byte_in  in  8  received byte, valid only when byte_valid=1
byte_valid  in  1  one-cycle strobe, byte complete
on_time  out  16  pulse on-time setting
period  out  16  burst period setting
out_en  out  1  output enable setting
cmd_ok  out  1  one-cycle strobe, frame accepted and applied
err  out  1  one-cycle strobe, frame rejected
err_code  out  2  reason for last err; held until next err

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low on rst_n. Asserting rst_n=0 forces state=IDLE, on_time=ON_TIME_DEFAULT, period=PERIOD_DEFAULT, out_en=0, cmd_ok=0, err=0, err_code=0 and clears the timeout counter, including mid-frame.
- States and transitions, all taken only on byte_valid:
  - IDLE: byte_in==HEADER -> CMD. Any other byte is ignored silently.
  - CMD: latch cmd -> DATA_LO.
  - DATA_LO: latch -> DATA_HI.
  - DATA_HI: latch -> CHECK.
  - CHECK: compare byte_in with the XOR of the latched bytes -> IDLE.
- Acceptance in CHECK (registers and cmd_ok update on the cycle after the CHK byte_valid):
  - Checksum mismatch: err=1, err_code=1, no register change.
  - cmd 8'h01: on_time = min({DATA_HI,DATA_LO}, ON_TIME_MAX).
  - cmd 8'h02: period = {DATA_HI,DATA_LO}. A value of 0 is rejected with err_code=3.
  - cmd 8'h03: out_en = DATA_LO[0].
  - Any other cmd: err=1, err_code=3.
  - Success: cmd_ok=1 for exactly one cycle.
- Timeout:
  - Counter clears on every byte_valid and counts only while state!=IDLE.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE with err=1, err_code=2.
  - If byte_valid coincides with expiry, the byte wins: it is processed and the counter clears.
- The HEADER value inside CMD/DATA/CHK positions is ordinary data and does not resync the frame.
- cmd_ok and err are never asserted together. Both are registered outputs with zero combinational paths from the inputs.
- byte_valid with state=CHECK is the last frame byte. A new HEADER is accepted on the very next strobe, with no dead cycle.
- on_time is not checked against period; the pulse generator owns that relation.

Decomposition:
- Shared package (common.sv) holds:
  - Parser state enum (IDLE, CMD, DATA_LO, DATA_HI, CHECK).
  - Command code constants (CMD_ON_TIME=1, CMD_PERIOD=2, CMD_ENABLE=3).
  - err_code constants (ERR_CHK=1, ERR_TIMEOUT=2, ERR_CMD=3).
  - Default values, reusing the existing `reg/`width macros for sizing.
- One sub-module, byte_timeout, holds:
  - Inputs: clk, rst_n, clear, run.
  - Output: one-cycle expire strobe.
  - Body: a counter sized with `width(TIMEOUT_CYCLES).

Test Plan:
- Frame AA 01 2C 01 2C (on_time=300) -> cmd_ok pulse one cycle after the last strobe; on_time=16'd300; err stays 0.
- Frame AA 01 F4 01 F4 (500 > ON_TIME_MAX) -> on_time=16'd400 clamped; cmd_ok=1.
- Frame AA 02 10 27 35 with last byte corrupted to 36 -> err=1, err_code=1; period stays 10000; next valid frame AA 03 01 00 02 -> out_en=1.
- Bytes AA 01 then no strobe for TIMEOUT_CYCLES -> err=1, err_code=2; state IDLE; then a full valid frame is accepted.
- Leading garbage 55 00 followed by AA 07 00 00 07 -> garbage ignored; err_code=3; no register change. rst_n pulse mid-frame after AA 01 -> all outputs at defaults, no err.
- byte_valid on the exact cycle the timeout would expire, at state DATA_LO -> no err; state advances to DATA_HI.
